ram_bus_serializer: RTL
=======================

# ram_bus_serializer

Single-port serializer between the core's word-level load/store/fetch requester and the 8-bit RAM/I-O bus. It converts one byte/half/word request into a sequence of byte bus cycles and, for reads, assembles the returned bytes into a sign- or zero-extended 32-bit response. It holds I/O writes while the UART buffer is full and freezes completely while `rdy` is low.

## Interface
Parameters:
- `IO_HI`, 2'b11: value of `addr[17:16]` that marks the I/O region.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `rdy`  in  1  pause when low; state is frozen and the bus is idle
- `req_valid_i`  in  1  request present
- `req_ready_o`  out  1  serializer can accept a request
- `req_wr_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  32  byte address of byte 0
- `req_size_i`  in  2  0 = byte, 1 = half, 2 = word, 3 = word (reserved alias)
- `req_signed_i`  in  1  sign-extend byte/half reads
- `req_data_i`  in  32  store data; byte i = bits [8i+7:8i]
- `resp_valid_o`  out  1  one-cycle completion pulse (read data or write ack)
- `resp_data_o`  out  32  extended read data; 0 for writes
- `ram_data_i`  in  8  bus read data; valid the cycle after its address
- `ram_data_o`  out  8  bus write data
- `ram_addr_o`  out  32  bus address
- `ram_wr_o`  out  1  1 = write cycle
- `io_buffer_full_i`  in  1  UART TX buffer full

## Operation
- States: IDLE, READ, WRITE. Byte count n = 1, 2, 4 from `req_size_i`.
- IDLE: `req_ready_o`=1. The bus is idle: `ram_wr_o`=0, `ram_addr_o`=0, `ram_data_o`=0. On `req_valid_i & rdy`, latch addr, n, wr, signed, data; clear counter c and the byte accumulator; go to READ or WRITE.
- READ, counter c in 0..n:
  - While c<n, drive `ram_addr_o`=base+c with `ram_wr_o`=0.
  - At each advancing edge with c≥1, store `ram_data_i` into byte c-1 of the accumulator, then c++.
  - At the edge where c==n, the final byte is captured and the block returns to IDLE with `resp_valid_o`=1.
- WRITE, counter c in 0..n-1:
  - Drive `ram_addr_o`=base+c, `ram_data_o`=byte c, `ram_wr_o`=1; c++ each advancing edge.
  - After byte n-1, return to IDLE with `resp_valid_o`=1.
  - If `base+c` has `[17:16]==IO_HI` and `io_buffer_full_i`=1: drive `ram_wr_o`=0, hold c, and retry each cycle.
- Extension: byte/half reads with `req_signed_i`=1 replicate bit 7 or bit 15; otherwise zero-fill. Word reads are passed through unmodified.
- Address arithmetic: 32-bit base+c; wraps at 2^32. No alignment check; misaligned accesses issue sequential bytes.
- rdy low: no state, counter or accumulator update; `ram_wr_o` forced 0. A read byte whose address was driven in the cycle just before an rdy-low cycle is re-issued after rdy returns (capture occurs only at an edge where both that cycle and the previous cycle had rdy=1).
- rst overrides rdy. Any in-flight request is dropped with no response.

## Timing
- Reset values: `req_ready_o`=1, `resp_valid_o`=0, `resp_data_o`=0, `ram_addr_o`=0, `ram_data_o`=0, `ram_wr_o`=0. State is IDLE.
- Acceptance edge is E0.
- Read: addresses driven in cycles 1..n, data captured at edges E2..E(n+1), `resp_valid_o` high in cycle n+2.
  - Word read: response in cycle 6.
  - Byte read: response in cycle 3.
- Write: bytes driven in cycles 1..n, ack in cycle n+2, plus one cycle per I/O hold.
- `resp_valid_o` is a single-cycle pulse, and `resp_data_o` is valid only while it is high.
  - The response cycle is IDLE, so a new request can be accepted in that same cycle (back-to-back).
- `req_ready_o`=0 in READ and WRITE; `req_valid_i` is ignored there.

## Test plan
- Word read at 0x00000100, RAM bytes 0x11,0x22,0x33,0x44 -> addresses 0x100..0x103 driven cycles 1-4; cycle 6 `resp_valid_o`=1, `resp_data_o`=0x44332211.
- Signed byte read of 0x80 -> 0xFFFFFF80; unsigned -> 0x00000080. Signed half read of 0x7FFF -> 0x00007FFF.
- Word write 0xDEADBEEF to 0x200 -> 4 cycles with `ram_wr_o`=1, data EF,BE,AD,DE at 0x200..0x203, ack in cycle 6.
- Byte write to 0x30000 with `io_buffer_full_i` high for 3 cycles -> `ram_wr_o` stays 0 for 3 cycles, then one write of the byte, then ack.
- `rdy` low for 2 cycles during a word read after byte1's address is driven -> byte1 is re-issued; final data is correct; response is delayed by 3 cycles.
- `rst` asserted mid-word-write -> next cycle all outputs are at reset values, no `resp_valid_o`, and a new request is accepted immediately.

Source files
------------

// File: rtl/ram_bus_serializer.sv
// rtl/ram_bus_serializer.sv - word request to 8-bit bus cycle serializer with read assembly and I/O hold
module ram_bus_serializer #(
    parameter logic [1:0] IO_HI = 2'b11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wr_i,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_data_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    input  logic [7:0]  ram_data_i,
    output logic [7:0]  ram_data_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_wr_o,
    input  logic        io_buffer_full_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic [31:0] r_acc;
    logic [1:0]  r_size;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;
    logic        r_signed;
    logic        r_rdy_prev;
    logic        r_resp_valid;
    logic [31:0] r_resp_data;

    logic [31:0] w_addr_cur;
    logic [31:0] w_addr_prev;
    logic        w_reissue;
    logic        w_hold;
    logic [7:0]  w_wbyte;
    logic [31:0] w_assembled;
    logic [31:0] w_extended;

    assign w_addr_cur  = r_base + {29'd0, r_cnt};
    assign w_addr_prev = w_addr_cur - 32'd1;
    // The byte addressed just before a pause came back while paused and was lost,
    // so the first cycle after the pause drives that address again.
    assign w_reissue   = (r_state == S_READ) && (r_cnt != 3'd0) && !r_rdy_prev;
    assign w_hold      = (r_state == S_WRITE) && (r_cnt < r_n) &&
                         (w_addr_cur[17:16] == IO_HI) && io_buffer_full_i;
    assign w_wbyte     = r_wdata[{r_cnt[1:0], 3'b000} +: 8];

    assign req_ready_o  = (r_state == S_IDLE);
    assign resp_valid_o = r_resp_valid;
    assign resp_data_o  = r_resp_data;

    // Merge the byte arriving this cycle into accumulator slot c-1.
    always_comb begin
        w_assembled = r_acc;
        case (r_cnt)
            3'd1:    w_assembled[7:0]   = ram_data_i;
            3'd2:    w_assembled[15:8]  = ram_data_i;
            3'd3:    w_assembled[23:16] = ram_data_i;
            3'd4:    w_assembled[31:24] = ram_data_i;
            default: w_assembled = r_acc;
        endcase
    end

    // Sign- or zero-extend byte/half results; words pass through.
    always_comb begin
        w_extended = w_assembled;
        case (r_size)
            2'd0:    w_extended = {{24{r_signed & w_assembled[7]}}, w_assembled[7:0]};
            2'd1:    w_extended = {{16{r_signed & w_assembled[15]}}, w_assembled[15:0]};
            default: w_extended = w_assembled;
        endcase
    end

    // Bus drive: idle outside transfers and whenever the core is paused.
    always_comb begin
        ram_addr_o = 32'd0;
        ram_data_o = 8'd0;
        ram_wr_o   = 1'b0;
        if (rdy) begin
            case (r_state)
                S_READ: begin
                    if (w_reissue) begin
                        ram_addr_o = w_addr_prev;
                    end else if (r_cnt < r_n) begin
                        ram_addr_o = w_addr_cur;
                    end
                end
                S_WRITE: begin
                    if (r_cnt < r_n) begin
                        ram_addr_o = w_addr_cur;
                        ram_data_o = w_wbyte;
                        ram_wr_o   = !w_hold;
                    end
                end
                default: begin
                    ram_addr_o = 32'd0;
                end
            endcase
        end
    end

    // Request sequencing: accept, step through bytes, pulse the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_base       <= 32'd0;
            r_wdata      <= 32'd0;
            r_acc        <= 32'd0;
            r_size       <= 2'd0;
            r_n          <= 3'd0;
            r_cnt        <= 3'd0;
            r_signed     <= 1'b0;
            r_rdy_prev   <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
        end else begin
            r_rdy_prev   <= rdy;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'd0;
            if (rdy) begin
                case (r_state)
                    S_IDLE: begin
                        if (req_valid_i) begin
                            r_base   <= req_addr_i;
                            r_wdata  <= req_data_i;
                            r_size   <= req_size_i;
                            r_signed <= req_signed_i;
                            r_cnt    <= 3'd0;
                            r_acc    <= 32'd0;
                            case (req_size_i)
                                2'd0:    r_n <= 3'd1;
                                2'd1:    r_n <= 3'd2;
                                default: r_n <= 3'd4;
                            endcase
                            r_state  <= req_wr_i ? S_WRITE : S_READ;
                        end
                    end
                    S_READ: begin
                        if (!w_reissue) begin
                            if (r_cnt == 3'd0) begin
                                r_cnt <= 3'd1;
                            end else begin
                                r_acc <= w_assembled;
                                if (r_cnt == r_n) begin
                                    r_state      <= S_IDLE;
                                    r_resp_valid <= 1'b1;
                                    r_resp_data  <= w_extended;
                                end else begin
                                    r_cnt <= r_cnt + 3'd1;
                                end
                            end
                        end
                    end
                    S_WRITE: begin
                        if (r_cnt == r_n) begin
                            r_state      <= S_IDLE;
                            r_resp_valid <= 1'b1;
                        end else if (!w_hold) begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
